// File: rtl/fetch_stage.sv
// fetch_stage: PC register and IF/ID pipeline register with redirect/stall/flush control.
// Optional fetch/stall counters are included when FETCH_STATS_EN is defined.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        id_valid
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        bubble;
    logic        load;

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;
    assign next_pc   = redirect ? {redirect_addr[31:2], 2'b00} : stall ? pc : pc_plus4;
    assign bubble    = redirect | flush;
    assign load      = !bubble && !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= next_pc;
        end
    end

    // A squashed slot keeps its id_pc/id_pc_plus4; only the instruction and valid bit clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_instr    <= '0;
            id_pc       <= '0;
            id_pc_plus4 <= '0;
            id_valid    <= 1'b0;
        end else if (bubble) begin
            id_instr <= '0;
            id_valid <= 1'b0;
        end else if (!stall) begin
            id_instr    <= imem_rdata;
            id_pc       <= pc;
            id_pc_plus4 <= pc_plus4;
            id_valid    <= 1'b1;
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (load && fetch_count != '1) fetch_count <= fetch_count + 32'd1;
            if (stall && !redirect && stall_count != '1) stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven and randomized self-checking bench for fetch_stage.
// A behavioural model tracks PC, IF/ID contents and counters from the control rules.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, flush = 1'b0, redirect = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic [31:0] imem_addr, imem_rdata, id_instr, id_pc, id_pc_plus4;
    logic        id_valid;
    logic [31:0] w_addr, w_rdata, w_instr, w_pc, w_p4;
    logic        w_valid;
`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count, stall_count, w_fc, w_sc;
`endif

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return (a == 32'h0) ? 32'h2010_0005 : ((a * 32'h9E37_79B1) ^ 32'h1357_9BDF);
    endfunction

    assign imem_rdata = imem(imem_addr);
    assign w_rdata    = imem(w_addr);

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .redirect(redirect),
        .redirect_addr(redirect_addr), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .id_valid(id_valid)
`ifdef FETCH_STATS_EN
        , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .stall(1'b0), .flush(1'b0), .redirect(1'b0),
        .redirect_addr(32'h0), .imem_addr(w_addr), .imem_rdata(w_rdata),
        .id_instr(w_instr), .id_pc(w_pc), .id_pc_plus4(w_p4), .id_valid(w_valid)
`ifdef FETCH_STATS_EN
        , .fetch_count(w_fc), .stall_count(w_sc)
`endif
    );

    // Reference state
    logic [31:0] m_pc, m_instr, m_idpc, m_p4, m_fc, m_sc;
    logic        m_valid;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_instr = '0; m_idpc = '0; m_p4 = '0; m_valid = 1'b0; m_fc = '0; m_sc = '0;
    endtask

    task automatic model_edge(input logic st, input logic fl, input logic rd, input logic [31:0] ra);
        if (rd) begin
            m_instr = '0;
            m_valid = 1'b0;
            m_pc    = ra & ~32'h3;
        end else begin
            if (st) m_sc = sat_inc(m_sc);
            if (fl) begin
                m_instr = '0;
                m_valid = 1'b0;
            end else if (!st) begin
                m_instr = imem(m_pc);
                m_idpc  = m_pc;
                m_p4    = m_pc + 32'd4;
                m_valid = 1'b1;
                m_fc    = sat_inc(m_fc);
            end
            if (!st) m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".imem_addr"}, imem_addr, m_pc);
        chk({tag, ".id_instr"}, id_instr, m_instr);
        chk({tag, ".id_pc"}, id_pc, m_idpc);
        chk({tag, ".id_pc_plus4"}, id_pc_plus4, m_p4);
        chk({tag, ".id_valid"}, {31'b0, id_valid}, {31'b0, m_valid});
`ifdef FETCH_STATS_EN
        chk({tag, ".fetch_count"}, fetch_count, m_fc);
        chk({tag, ".stall_count"}, stall_count, m_sc);
`endif
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge(stall, flush, redirect, redirect_addr);
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic st, input logic fl, input logic rd, input logic [31:0] ra);
        stall = st; flush = fl; redirect = rd; redirect_addr = ra;
    endtask

    typedef struct {
        logic        st, fl, rd;
        logic [31:0] ra;
        logic [31:0] e_addr, e_pc, e_p4, e_instr;
        logic        e_valid;
    } vec_t;

    vec_t tv[14];

    function automatic vec_t mk(input logic st, input logic fl, input logic rd, input logic [31:0] ra,
                                input logic [31:0] e_addr, input logic [31:0] e_pc,
                                input logic e_valid, input logic [31:0] e_instr);
        vec_t v;
        v.st = st; v.fl = fl; v.rd = rd; v.ra = ra;
        v.e_addr = e_addr; v.e_pc = e_pc; v.e_p4 = e_pc + 32'd4; v.e_valid = e_valid; v.e_instr = e_instr;
        return v;
    endfunction

    initial begin
        tv[0]  = mk(0, 0, 0, 0, 32'h04, 32'h00, 1, 32'h2010_0005);
        tv[1]  = mk(0, 0, 0, 0, 32'h08, 32'h04, 1, imem(32'h04));
        tv[2]  = mk(0, 0, 0, 0, 32'h0C, 32'h08, 1, imem(32'h08));
        tv[3]  = mk(0, 0, 0, 0, 32'h10, 32'h0C, 1, imem(32'h0C));
        tv[4]  = mk(1, 0, 0, 0, 32'h10, 32'h0C, 1, imem(32'h0C));
        tv[5]  = mk(1, 0, 0, 0, 32'h10, 32'h0C, 1, imem(32'h0C));
        tv[6]  = mk(1, 0, 0, 0, 32'h10, 32'h0C, 1, imem(32'h0C));
        tv[7]  = mk(0, 0, 0, 0, 32'h14, 32'h10, 1, imem(32'h10));
        tv[8]  = mk(0, 0, 0, 0, 32'h18, 32'h14, 1, imem(32'h14));
        tv[9]  = mk(0, 0, 0, 0, 32'h1C, 32'h18, 1, imem(32'h18));
        tv[10] = mk(0, 0, 0, 0, 32'h20, 32'h1C, 1, imem(32'h1C));
        tv[11] = mk(0, 1, 0, 0, 32'h24, 32'h1C, 0, 32'h0);
        tv[12] = mk(1, 0, 1, 32'h43, 32'h40, 32'h1C, 0, 32'h0);
        tv[13] = mk(0, 0, 0, 0, 32'h44, 32'h40, 1, imem(32'h40));

        // Reset state, asserted before any clock edge
        model_reset();
        #3;
        check_all("reset");
        #4 rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            drive(tv[i].st, tv[i].fl, tv[i].rd, tv[i].ra);
            step($sformatf("vec%0d", i));
            chk($sformatf("vec%0d.tbl_addr", i), imem_addr, tv[i].e_addr);
            chk($sformatf("vec%0d.tbl_pc", i), id_pc, tv[i].e_pc);
            chk($sformatf("vec%0d.tbl_p4", i), id_pc_plus4, tv[i].e_p4);
            chk($sformatf("vec%0d.tbl_instr", i), id_instr, tv[i].e_instr);
            chk($sformatf("vec%0d.tbl_valid", i), {31'b0, id_valid}, {31'b0, tv[i].e_valid});
            if (i == 0) begin
                chk("wrap.imem_addr", w_addr, 32'h0);
                chk("wrap.id_pc_plus4", w_p4, 32'h0);
                chk("wrap.id_pc", w_pc, 32'hFFFF_FFFC);
                chk("wrap.id_valid", {31'b0, w_valid}, 32'h1);
            end
        end
`ifdef FETCH_STATS_EN
        chk("tbl.fetch_count", fetch_count, 32'd9);
        chk("tbl.stall_count", stall_count, 32'd3);
`endif

        // Asynchronous reset landing between edges during a stall at PC=0x30
        drive(0, 0, 1, 32'h30);
        step("to30");
        drive(1, 0, 0, 0);
        step("stall30");
        #3 rst_n = 1'b0;
        model_reset();
        #1 check_all("async_rst");
        #1 rst_n = 1'b1;
        drive(0, 0, 0, 0);
        step("post_rst");
        chk("post_rst.first_instr", id_instr, 32'h2010_0005);

        // Randomized control traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 15,
                  $urandom_range(0, 99) < 10, $urandom);
            step($sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous reset, active-low.
REQ-004 stall  input  1  hazard-detection hold; freezes PC and IF/ID register.
REQ-005 flush  input  1  squash the instruction being loaded into IF/ID.
REQ-006 redirect  input  1  taken branch/jump from a later stage.
REQ-007 redirect_addr  input  32  target PC for redirect.
REQ-008 imem_addr  output  32  instruction memory address, equal to current PC.
REQ-009 imem_rdata  input  32  instruction word, combinational from imem_addr in the same cycle.
REQ-010 id_instr  output  32  registered instruction for decode.
REQ-011 id_pc  output  32  registered address of id_instr.
REQ-012 id_pc_plus4  output  32  registered id_pc + 4.
REQ-013 id_valid  output  1  id_instr is a real, non-squashed instruction.
REQ-014 fetch_count  output  32  valid instructions delivered (FETCH_STATS_EN only).
REQ-015 stall_count  output  32  stalled cycles (FETCH_STATS_EN only).

Function
REQ-016 imem_addr SHALL be driven directly from the PC register; no extra latency.
REQ-017 Latency: word at PC=A SHALL appear on id_instr with id_pc=A on the rising edge following its fetch.
REQ-018 Next-PC priority per edge: redirect > stall > sequential (PC+4).
REQ-019 redirect=1: PC <= {redirect_addr[31:2],2'b00}; IF/ID loads id_instr=0, id_valid=0, id_pc/id_pc_plus4 hold; applies even if stall=1.
REQ-020 stall=1, redirect=0, flush=0: PC and all id_* outputs SHALL hold their values.
REQ-021 flush=1, redirect=0: PC advances (or holds if stall=1); IF/ID loads id_instr=0, id_valid=0; flush overrides stall for the IF/ID register.
REQ-022 No control asserted: PC <= PC+4; IF/ID loads imem_rdata, PC, PC+4, id_valid=1.
REQ-023 PC and id_pc_plus4 arithmetic SHALL be modulo 2^32: PC 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-024 id_instr=0 (sll $0,$0,0) SHALL be the canonical bubble; decode treats it as a NOP regardless of id_valid.

Reset
REQ-025 rst_n low SHALL immediately, independent of clk: PC=RESET_PC, id_instr=0, id_pc=0, id_pc_plus4=0, id_valid=0, counters=0.
REQ-026 Reset asserted mid-stall or mid-redirect SHALL discard the pending action; first fetch after release is RESET_PC.
REQ-027 First rising edge after rst_n rises SHALL load IF/ID from RESET_PC when no control is asserted.

Configuration
REQ-028 Macro FETCH_STATS_EN defined: fetch_count and stall_count ports and counters exist.
REQ-029 fetch_count SHALL increment on every edge that loads id_valid=1; stall_count on every edge with stall=1 and redirect=0; both saturate at 32'hFFFF_FFFF.
REQ-030 Macro undefined: both ports and counter logic SHALL be absent; all other behaviour identical.

Verification
REQ-031 Reset release, imem returns 32'h2010_0005 at 0 -> after 1 edge id_instr=32'h2010_0005, id_pc=0, id_pc_plus4=4, id_valid=1, imem_addr=8 after 2 edges.
REQ-032 stall=1 for 3 cycles at PC=0x10 -> imem_addr stays 0x10, id_* unchanged, stall_count +3 (FETCH_STATS_EN).
REQ-033 redirect=1, redirect_addr=0x0000_0043, stall=1 same cycle -> PC=0x40 next edge, id_valid=0, id_instr=0; next edge id_pc=0x40.
REQ-034 flush=1 at PC=0x20, no stall -> id_valid=0, id_instr=0, PC=0x24; fetch_count not incremented.
REQ-035 RESET_PC=32'hFFFF_FFFC -> after 1 edge imem_addr=0, id_pc_plus4=0.
REQ-036 rst_n pulsed low between edges during stall at PC=0x30 -> outputs zero and PC=RESET_PC with no clock edge.
